// File: rtl/ysyx_22040750_pc_sched_pkg.sv
// Shared defines for the PC scheduler: FSM state encoding, reset fetch address
// and the redirect-target alignment helpers.
package ysyx_22040750_pc_sched_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

    // Trap vectors are word aligned; jump targets only drop bit 0 (jalr semantics).
    function automatic logic [31:0] align_trap(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] align_jmp(input logic [31:0] pc);
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_22040750_pc_sched_redir_buf.sv
// Redirect priority select (trap over jump) and the pending-target register
// that holds a redirect until IF accepts it.
module ysyx_22040750_pc_redir_buf
    import ysyx_22040750_pc_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_en_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    input  logic        jmp_en_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_pc_i,
    input  logic        load_i,
    output logic        redir_o,
    output logic [31:0] target_o,
    output logic [31:0] pend_pc_o
);

    logic        trap_take;
    logic        jmp_take;
    logic [31:0] pend_q;
    logic [31:0] pend_d;

    assign trap_take = trap_en_i & trap_valid_i;
    assign jmp_take  = jmp_en_i & jmp_valid_i;
    assign redir_o   = trap_take | jmp_take;
    assign target_o  = trap_take ? align_trap(trap_pc_i) : align_jmp(jmp_pc_i);
    assign pend_pc_o = pend_q;

    always_comb begin
        pend_d = pend_q;
        if (load_i) begin
            pend_d = target_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/ysyx_22040750_pc_sched.sv
// Fetch PC scheduler: sequential PC generation with trap/jump redirects,
// a one-entry hold for redirects IF cannot take yet, and a redirect counter.
module ysyx_22040750_pc_sched
    import ysyx_22040750_pc_sched_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_trap_valid,
    input  logic [31:0] I_trap_pc,
    input  logic        I_jmp_valid,
    input  logic [31:0] I_jmp_pc,
    input  logic        I_pc_ready,
    output logic        O_pc_valid,
    output logic [31:0] O_pc,
    output logic        O_flush,
    output logic [15:0] O_redir_cnt
);

    sched_state_e state_q;
    sched_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [15:0]  cnt_q;
    logic [15:0]  cnt_d;

    logic         redir;
    logic [31:0]  target;
    logic [31:0]  pend_pc;
    logic         buf_load;
    logic         pc_valid;
    logic [31:0]  pc_out;

    // Traps are honoured in RUN and HOLD; jumps only in RUN (a held jump wins).
    ysyx_22040750_pc_redir_buf u_redir_buf (
        .clk_i        (I_clk),
        .rst_i        (I_rst),
        .trap_en_i    (state_q != ST_BOOT),
        .trap_valid_i (I_trap_valid),
        .trap_pc_i    (I_trap_pc),
        .jmp_en_i     (state_q == ST_RUN),
        .jmp_valid_i  (I_jmp_valid),
        .jmp_pc_i     (I_jmp_pc),
        .load_i       (buf_load),
        .redir_o      (redir),
        .target_o     (target),
        .pend_pc_o    (pend_pc)
    );

    assign buf_load = redir & ~I_pc_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        pc_valid = 1'b0;
        pc_out   = pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_valid = 1'b1;
                pc_out   = redir ? target : pc_q;
                if (I_pc_ready) begin
                    pc_d = pc_out + PC_STEP;
                end else if (redir) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                pc_valid = 1'b1;
                pc_out   = redir ? target : pend_pc;
                if (I_pc_ready) begin
                    pc_d    = pc_out + PC_STEP;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        if (redir) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces the idle view immediately, before the registers are cleared.
    assign O_pc_valid  = pc_valid & ~I_rst;
    assign O_flush     = redir & ~I_rst;
    assign O_pc        = I_rst ? RESET_PC : pc_out;
    assign O_redir_cnt = I_rst ? 16'd0 : cnt_q;

endmodule

// File: tb/tb_ysyx_22040750_pc_sched.sv
// Randomized + directed bench for the PC scheduler; a cycle-level reference
// model feeds a scoreboard queue that a negedge monitor drains.
module tb_ysyx_22040750_pc_sched;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    typedef struct {
        bit          valid;
        bit          flush;
        logic [31:0] pc;
        logic [15:0] cnt;
        bit          lpc_en;
        logic [31:0] lpc;
        bit          lcnt_en;
        logic [15:0] lcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        trap_v;
    logic [31:0] trap_pc;
    logic        jmp_v;
    logic [31:0] jmp_pc;
    logic        rdy;
    logic        pc_valid;
    logic [31:0] pc;
    logic        flush;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [15:0] m_cnt;

    ysyx_22040750_pc_sched #(.RESET_PC(RST_PC)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_trap_valid (trap_v),
        .I_trap_pc    (trap_pc),
        .I_jmp_valid  (jmp_v),
        .I_jmp_pc     (jmp_pc),
        .I_pc_ready   (rdy),
        .O_pc_valid   (pc_valid),
        .O_pc         (pc),
        .O_flush      (flush),
        .O_redir_cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("valid", {31'd0, pc_valid}, {31'd0, mon_e.valid});
            chk("flush", {31'd0, flush}, {31'd0, mon_e.flush});
            chk("cnt", {16'd0, cnt}, {16'd0, mon_e.cnt});
            chk("pc", pc, mon_e.pc);
            if (mon_e.lpc_en) chk("pc_literal", pc, mon_e.lpc);
            if (mon_e.lcnt_en) chk("cnt_literal", {16'd0, cnt}, {16'd0, mon_e.lcnt});
        end
    end

    // One clock of stimulus; the reference model predicts this cycle's outputs
    // and then advances to the next cycle.
    task automatic cyc(input bit r, input bit tv, input logic [31:0] tp,
                       input bit jv, input logic [31:0] jp, input bit rd,
                       input bit lpe, input logic [31:0] lp,
                       input bit lce, input logic [15:0] lc);
        exp_t e;
        logic [31:0] tgt;
        bit          req;
        @(posedge clk);
        #1;
        rst = r; trap_v = tv; trap_pc = tp; jmp_v = jv; jmp_pc = jp; rdy = rd;
        e.lpc_en = lpe; e.lpc = lp; e.lcnt_en = lce; e.lcnt = lc;
        e.cnt = m_cnt;
        if (r) begin
            e.valid = 0; e.flush = 0; e.pc = RST_PC; e.cnt = 16'd0;
            m_mode = M_BOOT; m_pc = RST_PC; m_pend = 32'd0; m_cnt = 16'd0;
        end else if (m_mode == M_BOOT) begin
            e.valid = 0; e.flush = 0; e.pc = m_pc;
            m_mode = M_RUN;
        end else begin
            tgt = tv ? (tp & 32'hFFFF_FFFC) : (jp & 32'hFFFF_FFFE);
            req = tv || (jv && m_mode == M_RUN);
            e.valid = 1;
            e.flush = req;
            e.pc = req ? tgt : (m_mode == M_RUN ? m_pc : m_pend);
            if (rd) begin
                m_pc = e.pc + 32'd4;
                m_mode = M_RUN;
            end else if (req) begin
                m_pend = tgt;
                m_mode = M_HOLD;
            end
            if (req) m_cnt = m_cnt + 16'd1;
        end
        sb.push_back(e);
    endtask

    task automatic run_lit(input bit tv, input logic [31:0] tp, input bit jv,
                           input logic [31:0] jp, input bit rd, input logic [31:0] lp);
        cyc(0, tv, tp, jv, jp, rd, 1, lp, 0, 16'd0);
    endtask

    initial begin
        rst = 1; trap_v = 0; trap_pc = 0; jmp_v = 0; jmp_pc = 0; rdy = 1;
        m_mode = M_BOOT; m_pc = RST_PC; m_pend = 0; m_cnt = 0;

        // reset, boot bubble, sequential fetch
        cyc(1, 0, 0, 0, 0, 1, 1, RST_PC, 1, 16'd0);
        cyc(1, 0, 0, 0, 0, 1, 1, RST_PC, 1, 16'd0);
        cyc(0, 0, 0, 0, 0, 1, 1, RST_PC, 1, 16'd0);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0000);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0004);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0008);
        run_lit(0, 0, 0, 0, 1, 32'h8000_000C);
        // jump with ready: bypass and pc+4 after
        run_lit(0, 0, 1, 32'h8000_0101, 1, 32'h8000_0100);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0104, 1, 16'd1);
        // jump without ready: hold 3 cycles then handshake
        run_lit(0, 0, 1, 32'h8000_0200, 0, 32'h8000_0200);
        run_lit(0, 0, 0, 0, 0, 32'h8000_0200);
        run_lit(0, 0, 0, 0, 0, 32'h8000_0200);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0200);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0204);
        // trap beats jump
        run_lit(1, 32'h8000_0403, 1, 32'h8000_0300, 1, 32'h8000_0400);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0404, 1, 16'd3);
        // hold: later jump ignored, trap overrides
        run_lit(0, 0, 1, 32'h8000_0500, 0, 32'h8000_0500);
        run_lit(0, 0, 1, 32'h8000_0600, 0, 32'h8000_0500);
        run_lit(1, 32'h8000_0700, 0, 0, 0, 32'h8000_0700);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0700);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0704, 1, 16'd5);
        // hold + trap + ready together
        run_lit(0, 0, 1, 32'h8000_0800, 0, 32'h8000_0800);
        run_lit(1, 32'h8000_0900, 0, 0, 1, 32'h8000_0900);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0904);
        // PC wraps at 2^32
        run_lit(0, 0, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8);
        run_lit(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        run_lit(0, 0, 0, 0, 1, 32'h0000_0000);
        // reset while holding drops the pending target
        run_lit(0, 0, 1, 32'h1234_5678, 0, 32'h1234_5678);
        cyc(1, 0, 0, 0, 0, 0, 1, RST_PC, 1, 16'd0);
        cyc(0, 1, 32'h4000_0000, 1, 32'h4000_0000, 1, 1, RST_PC, 1, 16'd0);
        run_lit(0, 0, 0, 0, 1, 32'h8000_0000);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), $urandom,
                ($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 9) < 7),
                0, 0, 0, 0);
        end

        // counter wrap FFFF -> 0000
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 16'd0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65535; i++) begin
            cyc(0, 0, 0, 1, $urandom, 1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 16'hFFFF);
        cyc(0, 0, 0, 1, 32'h8000_0040, 1, 1, 32'h8000_0040, 1, 16'hFFFF);
        cyc(0, 0, 0, 0, 0, 1, 1, 32'h8000_0044, 1, 16'h0000);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_22040750_pc_sched.md
YSYX_22040750_PC_SCHED -- requirements
Module: ysyx_22040750_pc_sched

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have I_clk  input  1  clock.
REQ-003 SHALL have I_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have I_trap_valid  input  1  trap/interrupt/mret redirect request from CSR unit.
REQ-005 SHALL have I_trap_pc  input  32  trap target.
REQ-006 SHALL have I_jmp_valid  input  1  branch-taken/jal/jalr redirect request from EX.
REQ-007 SHALL have I_jmp_pc  input  32  jump target.
REQ-008 SHALL have I_pc_ready  input  1  IF accepts O_pc.
REQ-009 SHALL have O_pc_valid  output  1  O_pc valid.
REQ-010 SHALL have O_pc  output  32  next fetch address.
REQ-011 SHALL have O_flush  output  1  one-cycle kill of IF/ID and ID/EX contents.
REQ-012 SHALL have O_redir_cnt  output  16  count of accepted redirects.

Function
REQ-013 SHALL implement states BOOT, RUN, HOLD; BOOT entered on reset.
REQ-014 BOOT: O_pc_valid=0 for exactly one cycle, then RUN with pc_reg=RESET_PC.
REQ-015 RUN, no request: O_pc=pc_reg, O_pc_valid=1; on handshake (valid&ready) pc_reg<=pc_reg+4, wrapping modulo 2^32.
REQ-016 Redirect priority: trap > jmp; target = trap ? {I_trap_pc[31:2],2'b00} : {I_jmp_pc[31:1],1'b0}.
REQ-017 Any request in RUN or HOLD: O_flush=1 that cycle; O_pc=target combinationally (bypass) that cycle.
REQ-018 Request and I_pc_ready in same cycle: pc_reg<=target+4, remain RUN, no pending entry.
REQ-019 Request without I_pc_ready: target latched into pending register, go HOLD.
REQ-020 HOLD: O_pc=pending target, O_pc_valid=1, stable until handshake; on handshake pc_reg<=pending+4, go RUN.
REQ-021 HOLD + new trap: pending overwritten with trap target, O_flush=1; HOLD + new jmp only: ignored, O_flush=0.
REQ-022 HOLD + new trap + I_pc_ready same cycle: trap target issued (bypass), pc_reg<=trap target+4, go RUN.
REQ-023 O_pc may change while O_pc_valid=1 without handshake only in a cycle where O_flush=1.
REQ-024 O_redir_cnt SHALL increment by 1 per cycle with O_flush=1, wrapping FFFF->0000.
REQ-025 Requests in BOOT SHALL be ignored.
REQ-026 Outputs: O_flush, O_pc_valid combinational from state and inputs; no combinational path from I_pc_ready to O_pc.

Reset
REQ-027 I_rst SHALL override all events, taking effect at the clock edge where sampled high.
REQ-028 During reset and the following cycle: state=BOOT, O_pc_valid=0, O_flush=0, O_redir_cnt=0, pending cleared, pc_reg=RESET_PC, O_pc=RESET_PC.
REQ-029 Reset asserted while in HOLD SHALL discard the pending target.

Structure
REQ-030 State encoding and RESET_PC default SHALL be in the shared ysyx_22040750 defines package.
REQ-031 Pending target register plus priority select SHALL be sub-module ysyx_22040750_pc_redir_buf; the FSM, pc_reg and counter reside in the top.

Verification
REQ-032 Reset, ready=1 held -> cycle after reset valid=0; then O_pc 80000000, 80000004, 80000008 on consecutive cycles.
REQ-033 RUN pc=80000010, ready=1, jmp 80000101 -> O_flush=1, O_pc=80000100 same cycle, next O_pc=80000104, cnt=1.
REQ-034 ready=0, jmp 80000200 -> HOLD, O_pc=80000200 held 3 cycles, then ready=1 -> handshake, next O_pc=80000204.
REQ-035 Same cycle trap 80000403 and jmp 80000300, ready=1 -> O_pc=80000400, one flush, cnt+1.
REQ-036 HOLD on jmp 80000500, jmp 80000600 arrives -> ignored, O_flush=0; trap 80000700 arrives -> O_pc=80000700, cnt+1.
REQ-037 pc_reg=FFFFFFFC, handshake -> O_pc=00000000; cnt driven to FFFF then one more flush -> 0000.
